// File: rtl/fabric_config_loader.sv
// Bitstream loader for the tile/switch-box fabric: checks sync, pad bits and XOR checksum,
// writes each frame through a shared strobe bus and enables the fabric once the stream verifies.
module fabric_config_loader #(
    parameter int unsigned N_TILES   = 8,
    parameter int unsigned N_SBOX    = 7,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [32:0]        cfg_word,
    output logic [N_TILES-1:0] tile_we,
    output logic [N_SBOX-1:0]  sbox_we,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code,
    output logic               fabric_enable
);

    localparam int unsigned TW = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam int unsigned BW = (N_SBOX > 1) ? $clog2(N_SBOX) : 1;
    localparam int unsigned CW = 3;
    localparam logic [TW-1:0] LAST_TILE = TW'(N_TILES - 1);
    localparam logic [BW-1:0] LAST_BOX  = BW'(N_SBOX - 1);
    localparam logic [CW-1:0] TILE_LAST_BYTE = CW'(4);
    localparam logic [CW-1:0] SBOX_LAST_BYTE = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_TILE,
        S_SBOX,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [TW-1:0] tile_idx;
    logic [BW-1:0] box_idx;
    logic [CW-1:0] byte_cnt;
    logic [31:0]   shift;
    logic [7:0]    xsum;
    logic [1:0]    err_d;
    logic          clear;
    logic          xfer;
    logic          tile_fire;
    logic          sbox_fire;

    // Status decodes straight from the state register.
    assign din_ready     = (state == S_SYNC) || (state == S_TILE) ||
                           (state == S_SBOX) || (state == S_CHECK);
    assign busy          = din_ready;
    assign done          = (state == S_DONE);
    assign fabric_enable = (state == S_DONE);
    assign error         = (state == S_ERR);
    assign xfer          = din_valid & din_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and frame-completion decisions; start overrides any byte transfer.
    always_comb begin
        state_d   = state;
        err_d     = err_code;
        clear     = 1'b0;
        tile_fire = 1'b0;
        sbox_fire = 1'b0;
        if (start) begin
            state_d = S_SYNC;
            err_d   = 2'd0;
            clear   = 1'b1;
        end else begin
            case (state)
                S_SYNC: begin
                    if (xfer) begin
                        if (din == SYNC_BYTE) begin
                            state_d = S_TILE;
                        end else begin
                            state_d = S_ERR;
                            err_d   = 2'd1;
                        end
                    end
                end
                S_TILE: begin
                    if (xfer && (byte_cnt == TILE_LAST_BYTE)) begin
                        // Byte 4 carries bit 32 in din[0]; the rest is pad.
                        if (din[7:1] != 7'd0) begin
                            state_d = S_ERR;
                            err_d   = 2'd2;
                        end else begin
                            tile_fire = 1'b1;
                            if (tile_idx == LAST_TILE) begin
                                state_d = S_SBOX;
                            end
                        end
                    end
                end
                S_SBOX: begin
                    if (xfer && (byte_cnt == SBOX_LAST_BYTE)) begin
                        sbox_fire = 1'b1;
                        if (box_idx == LAST_BOX) begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        if (din == xsum) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ERR;
                            err_d   = 2'd3;
                        end
                    end
                end
                default: begin
                    state_d = state;
                end
            endcase
        end
    end

    // Payload assembly, running XOR, frame counters and the registered write bus.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tile_idx <= '0;
            box_idx  <= '0;
            byte_cnt <= '0;
            shift    <= '0;
            xsum     <= '0;
            err_code <= 2'd0;
            cfg_word <= '0;
            tile_we  <= '0;
            sbox_we  <= '0;
        end else begin
            tile_we  <= '0;
            sbox_we  <= '0;
            err_code <= err_d;
            if (clear) begin
                tile_idx <= '0;
                box_idx  <= '0;
                byte_cnt <= '0;
                shift    <= '0;
                xsum     <= '0;
            end else if (xfer && ((state == S_TILE) || (state == S_SBOX))) begin
                xsum  <= xsum ^ din;
                shift <= {din, shift[31:8]};
                if (state == S_TILE) begin
                    byte_cnt <= (byte_cnt == TILE_LAST_BYTE) ? '0 : byte_cnt + CW'(1);
                end else begin
                    byte_cnt <= (byte_cnt == SBOX_LAST_BYTE) ? '0 : byte_cnt + CW'(1);
                end
            end
            if (tile_fire) begin
                cfg_word          <= {din[0], shift};
                tile_we[tile_idx] <= 1'b1;
                tile_idx          <= tile_idx + TW'(1);
            end
            if (sbox_fire) begin
                cfg_word         <= {17'd0, din, shift[31:24]};
                sbox_we[box_idx] <= 1'b1;
                box_idx          <= box_idx + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader: nominal, error, backpressure, restart and reset loads.
module tb_fabric_config_loader;

    localparam int NB = 56;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic [32:0] cfg_word;
    logic [7:0]  tile_we;
    logic [6:0]  sbox_we;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic        fabric_enable;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int xfer_cyc = 0;
    int t6 = 0;

    logic [7:0]  strm [NB];
    logic [14:0] ev_we [$];
    logic [32:0] ev_word [$];
    int          ev_cyc [$];

    fabric_config_loader dut (
        .clock(clock), .reset(reset), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .cfg_word(cfg_word), .tile_we(tile_we), .sbox_we(sbox_we),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .fabric_enable(fabric_enable)
    );

    always #5 clock = ~clock;

    // Strobe recorder, sampled just after each rising edge.
    always @(posedge clock) begin
        cyc++;
        #1;
        if (|{sbox_we, tile_we}) begin
            ev_we.push_back({sbox_we, tile_we});
            ev_word.push_back(cfg_word);
            ev_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clock);
        din       = b;
        din_valid = 1'b1;
        while (!din_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!din_ready) begin
            check("send_timeout", 64'(din_ready), 64'd1);
            din_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        xfer_cyc  = cyc;
        din_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                repeat ($urandom_range(1, 3)) @(posedge clock);
            end
            send(strm[i]);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        ev_we.delete();
        ev_word.delete();
        ev_cyc.delete();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic build_nominal();
        for (int i = 0; i < NB; i++) strm[i] = 8'h00;
        strm[0] = 8'hA5;
        strm[1] = 8'h01;
        strm[5] = 8'h01;
    endtask

    task automatic build_pattern();
        logic [7:0] x;
        strm[0] = 8'hA5;
        for (int t = 0; t < 8; t++) begin
            strm[5*t+1] = 8'(t * 16 + 3);
            strm[5*t+2] = 8'(t * 7 + 64);
            strm[5*t+3] = 8'hC3 ^ 8'(t);
            strm[5*t+4] = 8'(255 - t);
            strm[5*t+5] = 8'(t & 1);
        end
        for (int b = 0; b < 7; b++) begin
            strm[41+2*b] = 8'(b * 37 + 5);
            strm[42+2*b] = 8'h80 | 8'(b);
        end
        x = 8'h00;
        for (int i = 1; i < NB - 1; i++) x = x ^ strm[i];
        strm[NB-1] = x;
    endtask

    // Expected strobe/word sequence derived from the stream bytes.
    task automatic check_events(input int nt, input int nb);
        check("ev_count", 64'(ev_we.size()), 64'(nt + nb));
        for (int i = 0; i < nt + nb && i < ev_we.size(); i++) begin
            logic [14:0] we;
            logic [32:0] w;
            if (i < nt) begin
                we = 15'(1) << i;
                w  = {strm[5*i+5][0], strm[5*i+4], strm[5*i+3], strm[5*i+2], strm[5*i+1]};
            end else begin
                we = 15'(1) << (8 + i - nt);
                w  = {17'd0, strm[42+2*(i-nt)], strm[41+2*(i-nt)]};
            end
            check($sformatf("ev%0d_we", i), 64'(ev_we[i]), 64'(we));
            check($sformatf("ev%0d_word", i), 64'(ev_word[i]), 64'(w));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; din = 8'h00; din_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_ready", 64'(din_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_flags", 64'({done, error, err_code, fabric_enable}), 64'd0);
        check("rst_bus", 64'({cfg_word, tile_we, sbox_we}), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_ready", 64'(din_ready), 64'd0);

        // Nominal load, valid held high
        build_nominal();
        pulse_start();
        check("sync_ready", 64'(din_ready), 64'd1);
        send_range(0, 5, 1'b0);
        t6 = xfer_cyc;
        send_range(6, 54, 1'b0);
        check("nom_done_early", 64'(done), 64'd0);
        send(strm[55]);
        @(negedge clock);
        check("nom_done", 64'(done), 64'd1);
        check("nom_fen", 64'(fabric_enable), 64'd1);
        check("nom_ready", 64'(din_ready), 64'd0);
        check("nom_busy", 64'(busy), 64'd0);
        if (ev_we.size() > 0) begin
            check("nom_t0_word", 64'(ev_word[0]), 64'h1_0000_0001);
            check("nom_t0_we", 64'(ev_we[0]), 64'h1);
            check("nom_t0_cyc", 64'(ev_cyc[0]), 64'(t6));
        end
        check_events(8, 7);
        repeat (3) @(negedge clock);
        check("nom_done_hold", 64'({done, fabric_enable, din_ready}), 64'b110);

        // Bad sync byte
        pulse_start();
        check("bs_done_clr", 64'(done), 64'd0);
        send(8'h5A);
        @(negedge clock);
        check("bs_error", 64'(error), 64'd1);
        check("bs_code", 64'(err_code), 64'd1);
        check("bs_ready", 64'(din_ready), 64'd0);
        check("bs_fen", 64'(fabric_enable), 64'd0);
        check("bs_strobes", 64'(ev_we.size()), 64'd0);

        // Nonzero pad in tile 3
        build_nominal();
        strm[20] = 8'h02;
        pulse_start();
        check("pad_err_clr", 64'(error), 64'd0);
        send_range(0, 20, 1'b0);
        repeat (2) @(negedge clock);
        check("pad_error", 64'(error), 64'd1);
        check("pad_code", 64'(err_code), 64'd2);
        check_events(3, 0);

        // Checksum mismatch, then clean restart
        build_nominal();
        strm[55] = 8'h01;
        pulse_start();
        send_range(0, 55, 1'b0);
        @(negedge clock);
        check_events(8, 7);
        check("ck_error", 64'(error), 64'd1);
        check("ck_code", 64'(err_code), 64'd3);
        check("ck_fen", 64'({fabric_enable, done}), 64'd0);
        strm[55] = 8'h00;
        pulse_start();
        check("ck_restart_clr", 64'({error, err_code}), 64'd0);
        send_range(0, 55, 1'b0);
        @(negedge clock);
        check("ck_restart_done", 64'({done, error}), 64'b10);

        // Patterned stream with random valid gaps
        build_pattern();
        pulse_start();
        send_range(0, 55, 1'b1);
        @(negedge clock);
        check_events(8, 7);
        check("bp_done", 64'(done), 64'd1);

        // Restart in the middle of tile 1
        pulse_start();
        send_range(0, 7, 1'b0);
        pulse_start();
        check("mid_sync", 64'({busy, din_ready, done}), 64'b110);
        send_range(0, 55, 1'b0);
        @(negedge clock);
        check_events(8, 7);
        check("mid_done", 64'(done), 64'd1);

        // Asynchronous reset in the middle of the switch-box frames
        pulse_start();
        send_range(0, 43, 1'b0);
        #2;
        check("rs_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("rs_ctl", 64'({din_ready, busy, done, error, err_code, fabric_enable}), 64'd0);
        check("rs_bus", 64'({cfg_word, tile_we, sbox_we}), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // start together with a valid checksum byte in CHECK
        pulse_start();
        send_range(0, 54, 1'b0);
        check("sc_busy", 64'(busy), 64'd1);
        @(negedge clock);
        start = 1'b1; din = strm[55]; din_valid = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0; din_valid = 1'b0;
        check("sc_state", 64'({done, din_ready, error}), 64'b010);
        send(strm[55]);
        @(negedge clock);
        check("sc_sync_code", 64'(err_code), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
